multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RISC-V core; replaces the single-cycle combinational main decoder. Sequences each RV32I instruction through fetch, decode, execute, memory and writeback states over a shared ALU and unified memory, and drives all datapath selects and write strobes. Supports an optional memory-ready handshake and configurable ecall/ebreak handling, and flags illegal opcodes through a sticky trap state.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// The controller takes the master side and drives every select and strobe.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic       BranchTaken;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       MemReq;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  op, BranchTaken, MemReady,
    output PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, InstrDone, IllegalOp, State
  );

  modport slave (
    output op, BranchTaken, MemReady,
    input  PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, InstrDone, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives all datapath selects and strobes.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE  = 1'b0,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input logic           clk,
  input logic           reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13,
    S_JALLINK  = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic [2:0] imm_sel(input logic [6:0] opc);
    case (opc)
      OP_STORE:          imm_sel = 3'b001;
      OP_BRANCH:         imm_sel = 3'b010;
      OP_JAL:            imm_sel = 3'b011;
      OP_LUI, OP_AUIPC:  imm_sel = 3'b100;
      default:           imm_sel = 3'b000;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_s;
  logic       ready_s;
  logic       pc_write_s, adr_src_s, mem_write_s, mem_req_s;
  logic       ir_write_s, reg_write_s, instr_done_s, illegal_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  assign ready_s = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_s       = state_r;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    mem_req_s    = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = ready_s;
        pc_write_s   = ready_s;
        if (ready_s) next_s = S_DECODE;
        else         next_s = S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: next_s = S_MEMADR;
          OP_RTYPE:          next_s = S_EXECR;
          OP_ITYPE:          next_s = S_EXECI;
          OP_BRANCH:         next_s = S_BRANCH;
          OP_JAL:            next_s = S_JAL;
          OP_JALR:           next_s = S_JALR;
          OP_LUI:            next_s = S_LUI;
          OP_AUIPC:          next_s = S_ALUWB;
          OP_SYSTEM: begin
            // ecall/ebreak either stop the core or retire as a nop here.
            if (HALT_ON_SYSTEM) begin
              next_s = S_HALT;
            end else begin
              next_s       = S_FETCH;
              instr_done_s = 1'b1;
            end
          end
          default:           next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (bus.op == OP_LOAD) next_s = S_MEMREAD;
        else                   next_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        mem_req_s = 1'b1;
        if (ready_s) next_s = S_MEMWB;
        else         next_s = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_s       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s    = 1'b1;
        mem_req_s    = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = ready_s;
        if (ready_s) next_s = S_FETCH;
        else         next_s = S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        next_s      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        next_s      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_s       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        pc_write_s   = bus.BranchTaken;
        instr_done_s = 1'b1;
        next_s       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        next_s      = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
        next_s       = S_JALLINK;
      end
      S_JALLINK: begin
        // Computes OldPC+4 for the link register; PC was already redirected.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        next_s      = S_ALUWB;
      end
      S_LUI: begin
        result_src_s = 2'b11;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_s       = S_FETCH;
      end
      S_HALT: begin
        next_s = S_HALT;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        next_s    = S_TRAP;
      end
      default: begin
        next_s = S_TRAP;
      end
    endcase
  end

  // Strobes are gated by reset so an aborted instruction cannot write anything.
  assign bus.PCWrite   = pc_write_s   & ~reset;
  assign bus.MemWrite  = mem_write_s  & ~reset;
  assign bus.MemReq    = mem_req_s    & ~reset;
  assign bus.IRWrite   = ir_write_s   & ~reset;
  assign bus.RegWrite  = reg_write_s  & ~reset;
  assign bus.InstrDone = instr_done_s & ~reset;
  assign bus.IllegalOp = illegal_s    & ~reset;
  assign bus.AdrSrc    = adr_src_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.ALUSrcA   = alu_src_a_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.ImmSrc    = imm_sel(bus.op);
  assign bus.State     = (state_r == S_JALLINK) ? S_JAL : state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two configurations driven with directed instructions,
// checked every cycle against a phase-list model plus hand-computed pins.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       mreq;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] ao;
    logic       done;
    logic       ill;
    logic [2:0] imm;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  m;
    obs_t  v;
    string nm;
  } pin_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
  localparam int P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;
  localparam int P_JAL = 10, P_JALR = 11, P_LUI = 12, P_HALT = 13, P_LINK = 14, P_TRAP = 15;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011, BADOP = 7'b1111111;

  localparam obs_t M_STROBE = '{st:4'hF, pcw:1'b1, mw:1'b1, mreq:1'b1, irw:1'b1,
                                rw:1'b1, done:1'b1, ill:1'b1, default:'0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if if_a ();
  multicycle_ctrl_if if_b ();

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .HALT_ON_SYSTEM(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .HALT_ON_SYSTEM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {if_a.State, if_a.PCWrite, if_a.AdrSrc, if_a.MemWrite, if_a.MemReq,
                  if_a.IRWrite, if_a.RegWrite, if_a.ResultSrc, if_a.ALUSrcA, if_a.ALUSrcB,
                  if_a.ALUOp, if_a.InstrDone, if_a.IllegalOp, if_a.ImmSrc};
  assign obs_b = {if_b.State, if_b.PCWrite, if_b.AdrSrc, if_b.MemWrite, if_b.MemReq,
                  if_b.IRWrite, if_b.RegWrite, if_b.ResultSrc, if_b.ALUSrcA, if_b.ALUSrcB,
                  if_b.ALUOp, if_b.InstrDone, if_b.IllegalOp, if_b.ImmSrc};

  bit    cur = 1'b0;  // 0: dut_a (no handshake, halt), 1: dut_b (handshake, nop)
  bit    exp_on = 1'b0;
  obs_t  exp_v;
  bit    lit_on = 1'b0;
  obs_t  lit_m, lit_v;
  string lit_nm = "";
  string tag = "";
  int    cyc_i = 0;
  int    errors = 0;
  int    checks = 0;
  pin_t  pins[$];

  // Expected outputs of one phase of an instruction, straight from the control table.
  function automatic obs_t expect_of(input int ph, input logic [6:0] opc, input bit rdy,
                                     input bit taken, input bit halt_cfg);
    obs_t e;
    e = '0;
    e.st = (ph == P_LINK) ? 4'd10 : ph[3:0];
    if (opc == STORE) e.imm = 3'b001;
    else if (opc == BRANCH) e.imm = 3'b010;
    else if (opc == JAL) e.imm = 3'b011;
    else if (opc == LUI || opc == AUIPC) e.imm = 3'b100;
    else e.imm = 3'b000;
    case (ph)
      P_FETCH:    begin e.mreq = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.irw = rdy; e.pcw = rdy; end
      P_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.done = (opc == SYSTEM) && !halt_cfg; end
      P_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      P_MEMREAD:  begin e.adr = 1'b1; e.mreq = 1'b1; end
      P_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      P_MEMWRITE: begin e.adr = 1'b1; e.mreq = 1'b1; e.mw = 1'b1; e.done = rdy; end
      P_EXECR:    begin e.sa = 2'b10; e.ao = 2'b10; end
      P_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.ao = 2'b10; end
      P_ALUWB:    begin e.rw = 1'b1; e.done = 1'b1; end
      P_BRANCH:   begin e.sa = 2'b10; e.ao = 2'b01; e.pcw = taken; e.done = 1'b1; end
      P_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      P_JALR:     begin e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; end
      P_LINK:     begin e.sa = 2'b01; e.sb = 2'b10; end
      P_LUI:      begin e.rs = 2'b11; e.rw = 1'b1; e.done = 1'b1; end
      P_TRAP:     begin e.ill = 1'b1; end
      default:    begin end
    endcase
    return e;
  endfunction

  // Compare process: model trace and literal pins, every negative edge.
  always @(negedge clk) begin : cmp
    obs_t act;
    act = cur ? obs_b : obs_a;
    if (exp_on) begin
      checks = checks + 1;
      if (act !== exp_v) begin
        errors = errors + 1;
        $display("FAIL model %s cycle %0d: got %h expected %h", tag, cyc_i, act, exp_v);
      end
    end
    if (lit_on) begin
      checks = checks + 1;
      if ((act & lit_m) !== lit_v) begin
        errors = errors + 1;
        $display("FAIL pin %s: got %h expected %h (mask %h)", lit_nm, act & lit_m, lit_v, lit_m);
      end
    end
  end

  task automatic drive(input logic [6:0] opc, input bit taken, input bit mr);
    if_a.op = opc; if_a.BranchTaken = taken; if_a.MemReady = mr;
    if_b.op = opc; if_b.BranchTaken = taken; if_b.MemReady = mr;
  endtask

  task automatic pin(input int c, input obs_t m, input obs_t v, input string nm);
    pin_t p;
    p.cyc = c; p.m = m; p.v = v; p.nm = nm;
    pins.push_back(p);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      drive(7'b0000000, 1'b0, 1'b0);
      exp_on = 1'b0;
      lit_on = (k >= 1);
      lit_m = M_STROBE; lit_v = '0; lit_nm = "reset_state";
    end
  endtask

  // Builds the phase list of one instruction (with wait and hold cycles) and plays it.
  task automatic run(input string nm, input logic [6:0] opc, input bit taken,
                     input int fw, input int mwt, input int hold);
    int ph[$];
    bit rd[$];
    for (int i = 0; i < fw; i++) begin ph.push_back(P_FETCH); rd.push_back(1'b0); end
    ph.push_back(P_FETCH);  rd.push_back(1'b1);
    ph.push_back(P_DECODE); rd.push_back(1'b0);
    case (opc)
      LOAD: begin
        ph.push_back(P_MEMADR); rd.push_back(1'b0);
        for (int i = 0; i < mwt; i++) begin ph.push_back(P_MEMREAD); rd.push_back(1'b0); end
        ph.push_back(P_MEMREAD); rd.push_back(1'b1);
        ph.push_back(P_MEMWB);   rd.push_back(1'b0);
      end
      STORE: begin
        ph.push_back(P_MEMADR); rd.push_back(1'b0);
        for (int i = 0; i < mwt; i++) begin ph.push_back(P_MEMWRITE); rd.push_back(1'b0); end
        ph.push_back(P_MEMWRITE); rd.push_back(1'b1);
      end
      RTYPE:  begin ph.push_back(P_EXECR); ph.push_back(P_ALUWB); rd.push_back(1'b0); rd.push_back(1'b0); end
      ITYPE:  begin ph.push_back(P_EXECI); ph.push_back(P_ALUWB); rd.push_back(1'b0); rd.push_back(1'b0); end
      AUIPC:  begin ph.push_back(P_ALUWB); rd.push_back(1'b0); end
      LUI:    begin ph.push_back(P_LUI); rd.push_back(1'b0); end
      BRANCH: begin ph.push_back(P_BRANCH); rd.push_back(1'b0); end
      JAL:    begin ph.push_back(P_JAL); ph.push_back(P_ALUWB); rd.push_back(1'b0); rd.push_back(1'b0); end
      JALR: begin
        ph.push_back(P_JALR); ph.push_back(P_LINK); ph.push_back(P_ALUWB);
        rd.push_back(1'b0); rd.push_back(1'b0); rd.push_back(1'b0);
      end
      SYSTEM: begin
        if (!cur) for (int i = 0; i < hold; i++) begin ph.push_back(P_HALT); rd.push_back(1'b0); end
      end
      default: begin
        for (int i = 0; i < hold; i++) begin ph.push_back(P_TRAP); rd.push_back(1'b0); end
      end
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      drive(opc, taken, cur ? rd[i] : 1'b0);
      exp_v  = expect_of(ph[i], opc, cur ? rd[i] : 1'b1, taken, !cur);
      exp_on = 1'b1;
      tag    = nm;
      cyc_i  = i;
      lit_on = 1'b0;
      foreach (pins[k]) begin
        if (pins[k].cyc == i) begin
          lit_on = 1'b1; lit_m = pins[k].m; lit_v = pins[k].v; lit_nm = pins[k].nm;
        end
      end
    end
    pins.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive(7'b0000000, 1'b0, 1'b0);

    // dut_a: single-cycle memory, system instructions halt
    cur = 1'b0;
    do_reset(3);
    pin(0, '{st:4'hF, irw:1'b1, pcw:1'b1, default:'0}, '{irw:1'b1, pcw:1'b1, default:'0}, "fetch_after_reset");
    pin(2, '{st:4'hF, rw:1'b1, done:1'b1, default:'0}, '{st:4'd2, default:'0}, "lw_memadr");
    pin(4, '{st:4'hF, rw:1'b1, done:1'b1, rs:2'b11, default:'0},
           '{st:4'd4, rw:1'b1, done:1'b1, rs:2'b01, default:'0}, "lw_memwb");
    run("lw", LOAD, 1'b0, 0, 0, 0);
    pin(3, '{st:4'hF, mw:1'b1, done:1'b1, default:'0}, '{st:4'd5, mw:1'b1, done:1'b1, default:'0}, "sw_nowait");
    run("sw", STORE, 1'b0, 0, 0, 0);
    run("r", RTYPE, 1'b0, 0, 0, 0);
    run("i", ITYPE, 1'b0, 0, 0, 0);
    pin(2, '{st:4'hF, rw:1'b1, done:1'b1, default:'0}, '{st:4'd8, rw:1'b1, done:1'b1, default:'0}, "auipc_wb");
    run("auipc", AUIPC, 1'b0, 0, 0, 0);
    pin(2, '{st:4'hF, rs:2'b11, rw:1'b1, default:'0}, '{st:4'd12, rs:2'b11, rw:1'b1, default:'0}, "lui");
    run("lui", LUI, 1'b0, 0, 0, 0);
    pin(2, '{st:4'hF, pcw:1'b1, done:1'b1, default:'0}, '{st:4'd9, done:1'b1, default:'0}, "br_not_taken");
    run("beq_nt", BRANCH, 1'b0, 0, 0, 0);
    pin(2, '{st:4'hF, pcw:1'b1, done:1'b1, default:'0}, '{st:4'd9, pcw:1'b1, done:1'b1, default:'0}, "br_taken");
    run("beq_t", BRANCH, 1'b1, 0, 0, 0);
    pin(2, '{st:4'hF, pcw:1'b1, sa:2'b11, sb:2'b11, default:'0},
           '{st:4'd10, pcw:1'b1, sa:2'b01, sb:2'b10, default:'0}, "jal_target");
    run("jal", JAL, 1'b0, 0, 0, 0);
    pin(2, '{st:4'hF, pcw:1'b1, rs:2'b11, default:'0}, '{st:4'd11, pcw:1'b1, rs:2'b10, default:'0}, "jalr_target");
    pin(3, '{st:4'hF, pcw:1'b1, sa:2'b11, sb:2'b11, default:'0},
           '{st:4'd10, sa:2'b01, sb:2'b10, default:'0}, "jalr_link");
    pin(4, '{st:4'hF, rw:1'b1, done:1'b1, default:'0}, '{st:4'd8, rw:1'b1, done:1'b1, default:'0}, "jalr_wb");
    run("jalr", JALR, 1'b0, 0, 0, 0);
    pin(1, '{st:4'hF, done:1'b1, default:'0}, '{st:4'd1, default:'0}, "sys_decode_halt");
    pin(5, M_STROBE, '{st:4'd13, default:'0}, "halt_quiet");
    run("ecall_halt", SYSTEM, 1'b0, 0, 0, 4);
    do_reset(3);
    pin(2, M_STROBE, '{st:4'hF, ill:1'b1, default:'0}, "trap_entry");
    pin(11, M_STROBE, '{st:4'hF, ill:1'b1, default:'0}, "trap_held");
    run("illegal", BADOP, 1'b0, 0, 0, 10);

    // dut_b: MemReady handshake, system instructions retire as nops
    do_reset(3);
    cur = 1'b1;
    pin(0, '{st:4'hF, irw:1'b1, pcw:1'b1, default:'0}, '{default:'0}, "fetch_wait");
    pin(2, '{st:4'hF, irw:1'b1, pcw:1'b1, default:'0}, '{irw:1'b1, pcw:1'b1, default:'0}, "fetch_ready");
    run("lw_wait", LOAD, 1'b0, 2, 1, 0);
    pin(3, '{mw:1'b1, done:1'b1, default:'0}, '{mw:1'b1, default:'0}, "sw_wait_first");
    pin(6, '{st:4'hF, mw:1'b1, done:1'b1, default:'0}, '{st:4'd5, mw:1'b1, done:1'b1, default:'0}, "sw_wait_last");
    run("sw_wait", STORE, 1'b0, 0, 3, 0);
    pin(1, '{st:4'hF, done:1'b1, default:'0}, '{st:4'd1, done:1'b1, default:'0}, "sys_nop_done");
    run("ecall_nop", SYSTEM, 1'b0, 0, 0, 0);
    pin(0, '{st:4'hF, default:'0}, '{default:'0}, "fetch_after_sys");
    run("lui_b", LUI, 1'b0, 0, 0, 0);
    run("beq_wait", BRANCH, 1'b1, 1, 0, 0);
    run("r_b", RTYPE, 1'b0, 0, 0, 0);

    @(posedge clk); #1;
    exp_on = 1'b0;
    lit_on = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
